// File: rtl/arm_multicycle_controller.sv
// rtl/arm_multicycle_controller.sv - multicycle FSM controller for the ARMv4 DP/LDR/STR/B subset
//
// Purpose: sequences the shared-memory, shared-ALU multicycle datapath. It drives the
// mux selects and write enables, and it holds the architectural NZCV flags.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   Instruction          instruction register (valid from DECODE onward)
//   ALUFlags             combinational NZCV from the ALU this cycle
//   MemReady             memory completes the access requested this cycle
//   PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
//                        datapath controls
//   Flags                architectural NZCV register
//   State                current FSM state (debug)
module arm_multicycle_controller #(
  parameter int ALU_CTRL_W    = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Instruction,
  input  logic [3:0]            ALUFlags,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            Flags,
  output logic [3:0]            State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam bit EXT_OPS = (ALU_CTRL_W >= 3);

  state_t      state, state_next;
  logic [3:0]  flags_q;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit, s_bit, u_bit, l_bit, rd_pc;
  logic [3:0]  cmd;
  logic        ready, cond_ex;
  logic        cmd_ok, cmd_nowrite, cmd_arith, alu_write;
  logic [2:0]  cmd_alu, alu_sel;
  logic [1:0]  imm_dec;
  logic        unused_bits;

  assign cond  = Instruction[31:28];
  assign op    = Instruction[27:26];
  assign i_bit = Instruction[25];
  assign cmd   = Instruction[24:21];
  assign u_bit = Instruction[23];
  assign s_bit = Instruction[20];
  assign l_bit = Instruction[20];
  assign rd_pc = (Instruction[15:12] == 4'hF);
  assign unused_bits = ^{Instruction[19:16], Instruction[11:0], alu_sel};

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = !flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = !flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = !flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = !flags_q[0];
      4'b1000: cond_ex = flags_q[1] && !flags_q[2];
      4'b1001: cond_ex = !flags_q[1] || flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing command decode; cmd_arith marks ops whose C/V are meaningful.
  always_comb begin
    cmd_ok      = 1'b1;
    cmd_nowrite = 1'b0;
    cmd_arith   = 1'b0;
    cmd_alu     = 3'b000;
    case (cmd)
      4'b0100: begin cmd_alu = 3'b000; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = 3'b001; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = 3'b010;
      4'b1100: cmd_alu = 3'b011;
      4'b1010: begin cmd_alu = 3'b001; cmd_arith = 1'b1; cmd_nowrite = 1'b1; end
      4'b1000: begin cmd_alu = 3'b010; cmd_nowrite = 1'b1; end
      4'b0001: begin cmd_alu = 3'b100; cmd_ok = EXT_OPS; end
      4'b1110: begin cmd_alu = 3'b101; cmd_ok = EXT_OPS; end
      4'b1101: begin cmd_alu = 3'b110; cmd_ok = EXT_OPS; end
      default: cmd_ok = 1'b0;
    endcase
  end

  assign alu_write = cmd_ok && !cmd_nowrite;
  assign imm_dec   = (op == 2'b10) ? 2'b10 : (op == 2'b01) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Flags capture in the execute state; decode of the next instruction sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if ((state == S_EXECUTER || state == S_EXECUTEI) && s_bit && cmd_ok) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (cmd_arith) begin
        flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_next = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    alu_sel    = 3'b000;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        PCWrite   = ready;
        state_next = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ImmSrc    = imm_dec;
        RegSrc    = {(op == 2'b01) && !l_bit, (op == 2'b10)};
        if (!cond_ex)            state_next = S_FETCH;
        else if (op == 2'b01)    state_next = S_MEMADR;
        else if (op == 2'b00)    state_next = i_bit ? S_EXECUTEI : S_EXECUTER;
        else if (op == 2'b10)    state_next = S_BRANCH;
        else                     state_next = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b01;
        RegSrc[1] = !l_bit;
        alu_sel   = u_bit ? 3'b000 : 3'b001;
        state_next = l_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        state_next = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCWrite   = rd_pc;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        RegSrc[1] = 1'b1;
        state_next = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_sel    = cmd_alu;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        alu_sel    = cmd_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = alu_write;
        PCWrite  = alu_write && rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        RegSrc[0] = 1'b1;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
    // Force every control low while reset is asserted, even mid-access.
    if (rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      RegSrc    = 2'b00;
      alu_sel   = 3'b000;
    end
  end

  assign ALUControl = alu_sel[ALU_CTRL_W-1:0];
  assign Flags      = flags_q;
  assign State      = state;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb/tb_arm_multicycle_controller.sv - directed self-checking bench for arm_multicycle_controller
module tb_arm_multicycle_controller;

  logic        clk;
  logic        rst, rst2;
  logic [31:0] Instruction, instr2;
  logic [3:0]  ALUFlags, flags_in2;
  logic        MemReady, ready2;

  logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic        ALUSrcA;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags, State;

  logic        pc_w2, adr_src2, mem_rd2, mem_wr2, ir_w2, reg_w2;
  logic [1:0]  res_src2, alu_b2, imm_src2, reg_src2;
  logic        alu_a2;
  logic [1:0]  alu_ctl2;
  logic [3:0]  flags2, state2;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arm_multicycle_controller #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  arm_multicycle_controller #(.ALU_CTRL_W(2), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .Instruction(instr2), .ALUFlags(flags_in2), .MemReady(ready2),
    .PCWrite(pc_w2), .AdrSrc(adr_src2), .MemRead(mem_rd2), .MemWrite(mem_wr2),
    .IRWrite(ir_w2), .RegWrite(reg_w2), .ResultSrc(res_src2), .ALUSrcA(alu_a2),
    .ALUSrcB(alu_b2), .ImmSrc(imm_src2), .RegSrc(reg_src2), .ALUControl(alu_ctl2),
    .Flags(flags2), .State(state2)
  );

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    Instruction = 32'hEC000000; instr2 = 32'hEC000000;
    ALUFlags = 4'b0000; flags_in2 = 4'b0000;
    MemReady = 1'b1; ready2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", State); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", Flags); end
    total++; if (MemRead !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || ALUSrcB !== 2'b00)
      begin bad++; $display("FAIL reset_ctrl got rd=%b ir=%b pc=%b srcb=%b want all 0", MemRead, IRWrite, PCWrite, ALUSrcB); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_adds();
    logic [3:0] exp_st [0:3];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
    Instruction = 32'hE0921003; ALUFlags = 4'b1001; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (State !== exp_st[i]) begin bad++; $display("FAIL adds_state[%0d] got=%0d want=%0d", i, State, exp_st[i]); end
      total++; if (RegWrite !== (i == 3)) begin bad++; $display("FAIL adds_regwrite[%0d] got=%b want=%b", i, RegWrite, (i == 3)); end
      if (i == 0) begin
        total++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || MemRead !== 1'b1)
          begin bad++; $display("FAIL adds_fetch got ir=%b pc=%b rd=%b want 111", IRWrite, PCWrite, MemRead); end
      end
      if (i == 2) begin
        total++; if (ALUControl !== 3'b000) begin bad++; $display("FAIL adds_aluctl got=%b want=000", ALUControl); end
      end
      @(negedge clk);
    end
    total++; if (Flags !== 4'b1001) begin bad++; $display("FAIL adds_flags got=%b want=1001", Flags); end
  endtask

  task automatic test_ldr_wait();
    logic [3:0] exp_st [0:7];
    logic       rdy    [0:7];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    Instruction = 32'hE5910004;
    for (int i = 0; i < 8; i++) begin
      MemReady = rdy[i];
      #1;
      total++; if (State !== exp_st[i]) begin bad++; $display("FAIL ldr_state[%0d] got=%0d want=%0d", i, State, exp_st[i]); end
      total++; if (RegWrite !== (i == 7)) begin bad++; $display("FAIL ldr_regwrite[%0d] got=%b want=%b", i, RegWrite, (i == 7)); end
      if (i >= 3 && i <= 6) begin
        total++; if (MemRead !== 1'b1 || AdrSrc !== 1'b1)
          begin bad++; $display("FAIL ldr_memread[%0d] got rd=%b adr=%b want 11", i, MemRead, AdrSrc); end
      end
      if (i == 7) begin
        total++; if (ResultSrc !== 2'b01) begin bad++; $display("FAIL ldr_resultsrc got=%b want=01", ResultSrc); end
      end
      @(negedge clk);
    end
    MemReady = 1'b1;
  endtask

  task automatic test_str_reset();
    logic [3:0] exp_st [0:3];
    logic       rdy    [0:3];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0};
    Instruction = 32'hE5810004;
    for (int i = 0; i < 4; i++) begin
      MemReady = rdy[i];
      #1;
      total++; if (State !== exp_st[i]) begin bad++; $display("FAIL str_state[%0d] got=%0d want=%0d", i, State, exp_st[i]); end
      if (i == 1) begin
        total++; if (RegSrc !== 2'b10) begin bad++; $display("FAIL str_regsrc got=%b want=10", RegSrc); end
      end
      if (i < 3) @(negedge clk);
    end
    total++; if (MemWrite !== 1'b1) begin bad++; $display("FAIL str_memwrite got=%b want=1", MemWrite); end
    total++; if (Flags !== 4'b1001) begin bad++; $display("FAIL str_flags_pre got=%b want=1001", Flags); end
    #2 rst = 1'b1;
    #1;
    total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b want=0", MemWrite); end
    total++; if (State !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", State); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", Flags); end
    @(negedge clk);
    rst = 1'b0; MemReady = 1'b1;
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] exp_st [0:3];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
    Instruction = 32'hE0521003; ALUFlags = z ? 4'b0100 : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (State !== exp_st[i]) begin bad++; $display("FAIL subs_state[%0d] got=%0d want=%0d", i, State, exp_st[i]); end
      if (i == 2) begin
        total++; if (ALUControl !== 3'b001) begin bad++; $display("FAIL subs_aluctl got=%b want=001", ALUControl); end
      end
      @(negedge clk);
    end
    total++; if (Flags !== (z ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL subs_flags got=%b want z=%b", Flags, z); end
    Instruction = 32'h0A000002;
    if (z) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        total++; if (State !== 4'(i == 2 ? 9 : i)) begin bad++; $display("FAIL beq_t_state[%0d] got=%0d", i, State); end
        total++; if (PCWrite !== (i != 1)) begin bad++; $display("FAIL beq_t_pcwrite[%0d] got=%b want=%b", i, PCWrite, (i != 1)); end
        if (i == 2) begin
          total++; if (ImmSrc !== 2'b10 || RegSrc !== 2'b01 || ResultSrc !== 2'b10)
            begin bad++; $display("FAIL beq_t_ctrl got imm=%b reg=%b res=%b want 10 01 10", ImmSrc, RegSrc, ResultSrc); end
        end
        @(negedge clk);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        #1;
        total++; if (State !== 4'(i)) begin bad++; $display("FAIL beq_n_state[%0d] got=%0d want=%0d", i, State, i); end
        total++; if (PCWrite !== (i == 0)) begin bad++; $display("FAIL beq_n_pcwrite[%0d] got=%b want=%b", i, PCWrite, (i == 0)); end
        @(negedge clk);
      end
      #1;
      total++; if (State !== 4'd0) begin bad++; $display("FAIL beq_n_return got=%0d want=0", State); end
    end
  endtask

  task automatic test_dp(input logic [31:0] ins, input logic [3:0] aflags, input logic [3:0] exec_st,
                         input logic [2:0] exp_ctl, input logic exp_wr, input logic [3:0] exp_flags);
    Instruction = ins; ALUFlags = aflags;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (State !== (i == 0 ? 4'd0 : i == 1 ? 4'd1 : i == 2 ? exec_st : 4'd8))
        begin bad++; $display("FAIL dp_%h_state[%0d] got=%0d", ins, i, State); end
      total++; if (RegWrite !== (exp_wr && i == 3))
        begin bad++; $display("FAIL dp_%h_regwrite[%0d] got=%b want=%b", ins, i, RegWrite, (exp_wr && i == 3)); end
      if (i == 2) begin
        total++; if (ALUControl !== exp_ctl) begin bad++; $display("FAIL dp_%h_aluctl got=%b want=%b", ins, ALUControl, exp_ctl); end
        total++; if (ALUSrcB !== (exec_st == 4'd7 ? 2'b01 : 2'b00))
          begin bad++; $display("FAIL dp_%h_srcb got=%b", ins, ALUSrcB); end
      end
      @(negedge clk);
    end
    total++; if (Flags !== exp_flags) begin bad++; $display("FAIL dp_%h_flags got=%b want=%b", ins, Flags, exp_flags); end
  endtask

  task automatic test_narrow_nohs();
    logic [3:0] exp_ld [0:4];
    exp_ld = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    rst2 = 1'b0; instr2 = 32'hE0321003; flags_in2 = 4'b1111; ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state2 !== (i == 0 ? 4'd0 : i == 1 ? 4'd1 : i == 2 ? 4'd6 : 4'd8))
        begin bad++; $display("FAIL w2_eor_state[%0d] got=%0d", i, state2); end
      if (i == 0) begin
        total++; if (ir_w2 !== 1'b1) begin bad++; $display("FAIL w2_nostall_irwrite got=%b want=1", ir_w2); end
      end
      if (i == 3) begin
        total++; if (reg_w2 !== 1'b0) begin bad++; $display("FAIL w2_eor_regwrite got=%b want=0", reg_w2); end
      end
      @(negedge clk);
    end
    total++; if (flags2 !== 4'b0000) begin bad++; $display("FAIL w2_eor_flags got=%b want=0000", flags2); end
    instr2 = 32'hE5910004;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state2 !== exp_ld[i]) begin bad++; $display("FAIL nohs_ldr_state[%0d] got=%0d want=%0d", i, state2, exp_ld[i]); end
      total++; if (reg_w2 !== (i == 4)) begin bad++; $display("FAIL nohs_ldr_regwrite[%0d] got=%b", i, reg_w2); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_ldr_wait();
    test_str_reset();
    test_beq(1'b1);
    test_beq(1'b0);
    // CMP R1,R2: flags from ALU, no write
    test_dp(32'hE1510002, 4'b0010, 4'd6, 3'b001, 1'b0, 4'b0010);
    // EORS: extended op writes; NZ updated, CV held
    test_dp(32'hE0321003, 4'b1111, 4'd6, 3'b100, 1'b1, 4'b1110);
    // ORR R1,R2,#5: immediate path, no S so flags held
    test_dp(32'hE3821005, 4'b0000, 4'd7, 3'b011, 1'b1, 4'b1110);
    test_narrow_nohs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
